adq_mem_master: RTL and testbench
=================================

// Module: adq_mem_master
// PURPOSE
//  Initiator for the ADQ_SYS single-port sample memory (en/wr/add/din/dout port).
//  - Acquisition: writes an N-sample burst from the sample stream into memory, starting at address 0.
//  - Readback: reads the stored burst and streams it out on a valid/ready interface.
//  - Sits between the acquisition front end and the downstream consumer/host.
// PARAMETERS
//  DATA_W  32  sample and memory word width
//  ADD_S   8   memory address width; capacity 2**ADD_S words
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset, synchronous, active-high
//  start_acq  in   1         pulse: begin a capture burst (ignored unless IDLE)
//  n_samples  in   ADD_S+1   burst length, latched on start_acq
//  smp_valid  in   1         sample strobe; no backpressure
//  smp_data   in   DATA_W    sample word
//  start_rd   in   1         pulse: begin readback of last capture (ignored unless IDLE)
//  rd_valid   out  1         rd_data valid
//  rd_ready   in   1         consumer accepts beat when rd_valid & rd_ready
//  rd_data    out  DATA_W    readback word
//  rd_last    out  1         marks the final readback beat (qualified by rd_valid)
//  busy       out  1         state != IDLE
//  acq_done   out  1         1-cycle pulse: capture complete
//  rd_done    out  1         1-cycle pulse: readback complete
//  mem_en     out  1         memory enable
//  mem_wr     out  1         1 = write, 0 = read
//  mem_add    out  ADD_S     memory address
//  mem_din    out  DATA_W    memory write data
//  mem_dout   in   DATA_W    memory read data; valid 1 cycle after read issue, held while mem_en=0
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - state=IDLE; cap_len=0; pointers=0.
//  - All outputs 0; memory contents are not cleared.
//  - Reset mid-burst aborts the burst immediately; no done pulse is generated.
//  FSM states: IDLE, CAPTURE, READ. Transitions:
//  - IDLE->CAPTURE on start_acq.
//  - IDLE->READ on start_rd when cap_len!=0.
//  - start_acq and start_rd in the same cycle: start_acq wins; start_rd is dropped.
//  - start_* while busy: ignored.
//  Length handling:
//  - n_samples==0 or >2**ADD_S: clamp to 2**ADD_S.
//  - The latched length becomes cap_len only when capture completes.
//  CAPTURE:
//  - Combinational: mem_en=mem_wr=smp_valid; mem_add=wr_ptr; mem_din=smp_data.
//  - wr_ptr starts at 0 and increments per written sample. Gaps in smp_valid are allowed.
//  - Completion: on the cycle the Nth sample is written, go to IDLE.
//  - On that transition: cap_len<=N; acq_done=1 on the following cycle.
//  READ:
//  - Issue a read (mem_en=1, mem_wr=0, mem_add=rd_ptr) when rd_ptr<cap_len and (!rd_valid | rd_ready).
//  - rd_valid is a register: set the cycle after an issue; cleared on accept with no new issue.
//  - rd_data=mem_dout, a direct pass-through; it relies on the memory holding dout while en=0.
//  - Throughput is 1 beat/cycle with rd_ready high. Read latency is 1 cycle (start_rd -> first issue).
//  - Under backpressure, rd_data and rd_valid are held stable and no new read is issued.
//  - rd_last=rd_valid & (beat index==cap_len-1).
//  - After the last beat is accepted: go to IDLE; rd_done=1 the next cycle.
//  - start_rd with cap_len==0: stay IDLE, rd_done pulse next cycle, no memory access.
//  Wrap-around:
//  - Pointers are ADD_S+1 bits, so the full-depth burst (2**ADD_S) ends cleanly.
//  - mem_add uses the low ADD_S bits.
//  - Readback may repeat any number of times; each readback rereads from address 0.
//  Outside CAPTURE and READ issue cycles: mem_en=0, mem_wr=0.
// TESTING
//  - Reset then start_rd -> no mem_en, rd_done pulse 1 cycle later, rd_valid stays 0.
//  - n_samples=4, smp_valid continuous with data 0xA0..0xA3 -> writes to addr 0..3, acq_done pulse.
//    Then start_rd, rd_ready=1 -> 4 beats 0xA0..0xA3 on consecutive cycles, rd_last on 0xA3, rd_done.
//  - Readback with rd_ready toggling 1,0,0,1 -> rd_data held during stalls; no beat lost or duplicated.
//  - n_samples=0 (ADD_S=4) -> 16 writes to addr 0..15, then 16 read beats; mem_add wraps only after the end.
//  - smp_valid gapped (1,0,1,1,0,1), N=4 -> exactly 4 writes at consecutive addresses.
//  - Simultaneous start_acq+start_rd -> capture runs.
//  - rst asserted mid-READ -> all outputs 0 next cycle, no rd_done, cap_len=0.

Source files
------------

// File: rtl/adq_mem_master.sv
// rtl/adq_mem_master.sv - capture/readback initiator for the ADQ single-port sample memory
// Writes an N-sample burst from address 0, then streams it back on a valid/ready port.
module adq_mem_master #(
    parameter int DATA_W = 32,
    parameter int ADD_S  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_acq,
    input  logic [ADD_S:0]    n_samples,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              start_rd,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              acq_done,
    output logic              rd_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADD_S-1:0]  mem_add,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADD_S:0] DEPTH   = {1'b1, {ADD_S{1'b0}}};
    localparam logic [ADD_S:0] PTR_ONE = {{ADD_S{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [ADD_S:0] len_q, len_d;
    logic [ADD_S:0] cap_len_q, cap_len_d;
    logic [ADD_S:0] wr_ptr_q, wr_ptr_d;
    logic [ADD_S:0] rd_ptr_q, rd_ptr_d;
    logic           rd_valid_q, rd_valid_d;
    logic           acq_done_q, acq_done_d;
    logic           rd_done_q, rd_done_d;
    logic           rd_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cap_len_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            acq_done_q <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cap_len_q  <= cap_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            acq_done_q <= acq_done_d;
            rd_done_q  <= rd_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cap_len_d  = cap_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        acq_done_d = 1'b0;
        rd_done_d  = 1'b0;
        rd_issue   = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_add    = '0;
        mem_din    = '0;

        case (state_q)
            IDLE: begin
                if (start_acq) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                    len_d    = (n_samples == '0 || n_samples > DEPTH) ? DEPTH : n_samples;
                end else if (start_rd) begin
                    if (cap_len_q != '0) begin
                        state_d    = READ;
                        rd_ptr_d   = '0;
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_done_d = 1'b1;
                    end
                end
            end

            CAPTURE: begin
                mem_en  = smp_valid;
                mem_wr  = smp_valid;
                mem_add = wr_ptr_q[ADD_S-1:0];
                mem_din = smp_data;
                if (smp_valid) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    // cap_len only takes the new length once the burst is complete
                    if (wr_ptr_q + PTR_ONE == len_q) begin
                        state_d    = IDLE;
                        cap_len_d  = len_q;
                        acq_done_d = 1'b1;
                    end
                end
            end

            READ: begin
                rd_issue = (rd_ptr_q < cap_len_q) && (!rd_valid_q || rd_ready);
                if (rd_issue) begin
                    mem_en     = 1'b1;
                    mem_add    = rd_ptr_q[ADD_S-1:0];
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    rd_valid_d = 1'b1;
                end else if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (rd_last) begin
                        state_d   = IDLE;
                        rd_done_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // The held beat is always the most recently issued one, i.e. index rd_ptr_q-1.
    assign rd_last  = rd_valid_q && (rd_ptr_q == cap_len_q);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? mem_dout : '0;
    assign busy     = (state_q != IDLE);
    assign acq_done = acq_done_q;
    assign rd_done  = rd_done_q;

endmodule

// File: tb/tb_adq_mem_master.sv
// tb/tb_adq_mem_master.sv - randomized directed bench for adq_mem_master
// Memory is modelled behaviourally; expectations come from a sample array plus burst length.
module tb_adq_mem_master;

    localparam int DATA_W = 32;
    localparam int ADD_S  = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_acq;
    logic [ADD_S:0]    n_samples;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic              start_rd;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              acq_done;
    logic              rd_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADD_S-1:0]  mem_add;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout = '0;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    int                wlog_add[$];
    logic [DATA_W-1:0] wlog_dat[$];
    int                rlog_add[$];

    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                ref_len = 0;

    always #5 clk = ~clk;

    adq_mem_master #(.DATA_W(DATA_W), .ADD_S(ADD_S)) dut (
        .clk(clk), .rst(rst), .start_acq(start_acq), .n_samples(n_samples),
        .smp_valid(smp_valid), .smp_data(smp_data), .start_rd(start_rd),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .acq_done(acq_done), .rd_done(rd_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_add(mem_add), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // single-port memory: read data appears one cycle after issue and is held while idle
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) begin
                mem[mem_add] <= mem_din;
                wlog_add.push_back(int'(mem_add));
                wlog_dat.push_back(mem_din);
            end else begin
                mem_dout <= mem[mem_add];
                rlog_add.push_back(int'(mem_add));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},     64'(busy),     64'd0);
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, ".rd_data"},  64'(rd_data),  64'd0);
        chk({tag, ".rd_last"},  64'(rd_last),  64'd0);
        chk({tag, ".acq_done"}, 64'(acq_done), 64'd0);
        chk({tag, ".rd_done"},  64'(rd_done),  64'd0);
        chk({tag, ".mem_en"},   64'(mem_en),   64'd0);
        chk({tag, ".mem_wr"},   64'(mem_wr),   64'd0);
        chk({tag, ".mem_add"},  64'(mem_add),  64'd0);
        chk({tag, ".mem_din"},  64'(mem_din),  64'd0);
    endtask

    // mode 0: continuous, 1: gap pattern 1,0,1,1,0,1, 2: random gaps; base>=0 gives fixed data
    task automatic do_capture(input int n, input int mode, input int base, input bit also_rd);
        int n_eff;
        int w0;
        int sent;
        int k;
        bit v;
        n_eff = (n == 0 || n > DEPTH) ? DEPTH : n;
        w0 = wlog_add.size();
        start_acq = 1'b1;
        start_rd  = also_rd;
        n_samples = (ADD_S+1)'(n);
        tick;
        start_acq = 1'b0;
        start_rd  = 1'b0;
        chk("cap.busy", 64'(busy), 64'd1);
        sent = 0;
        k = 0;
        while (sent < n_eff && k < 400) begin
            chk("cap.acq_done_early", 64'(acq_done), 64'd0);
            case (mode)
                0:       v = 1'b1;
                1:       v = !((k % 6) == 1 || (k % 6) == 4);
                default: v = 1'($urandom_range(0, 1));
            endcase
            smp_valid = v;
            smp_data  = (base >= 0) ? DATA_W'(base + sent) : $urandom;
            if (v) begin
                ref_mem[sent] = smp_data;
                sent++;
            end
            k++;
            tick;
        end
        chk("cap.sent", 64'(sent), 64'(n_eff));
        chk("cap.acq_done", 64'(acq_done), 64'd1);
        chk("cap.busy_end", 64'(busy), 64'd0);
        smp_valid = 1'b1;
        smp_data  = $urandom;
        tick;
        smp_valid = 1'b0;
        chk("cap.acq_done_pulse", 64'(acq_done), 64'd0);
        tick;
        chk("cap.nwrites", 64'(wlog_add.size() - w0), 64'(n_eff));
        for (int i = 0; i < n_eff && w0 + i < wlog_add.size(); i++) begin
            chk("cap.waddr", 64'(wlog_add[w0+i]), 64'(i));
            chk("cap.wdata", 64'(wlog_dat[w0+i]), 64'(ref_mem[i]));
        end
        ref_len = n_eff;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic do_read(input int mode);
        int r0;
        int w0;
        int beat;
        int cyc;
        bit stalled;
        bit rdy;
        logic [DATA_W-1:0] held;
        r0 = rlog_add.size();
        w0 = wlog_add.size();
        start_rd = 1'b1;
        tick;
        start_rd = 1'b0;
        if (ref_len == 0) begin
            chk("rd0.rd_done", 64'(rd_done), 64'd1);
            chk("rd0.busy", 64'(busy), 64'd0);
            chk("rd0.rd_valid", 64'(rd_valid), 64'd0);
            tick;
            chk("rd0.rd_done_pulse", 64'(rd_done), 64'd0);
            chk("rd0.rd_valid2", 64'(rd_valid), 64'd0);
            chk("rd0.nreads", 64'(rlog_add.size() - r0), 64'd0);
            return;
        end
        chk("rd.busy", 64'(busy), 64'd1);
        chk("rd.first_valid", 64'(rd_valid), 64'd0);
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (beat < ref_len && cyc < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0 || (cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            chk("rd.rd_done_early", 64'(rd_done), 64'd0);
            if (stalled) begin
                chk("rd.hold_valid", 64'(rd_valid), 64'd1);
                chk("rd.hold_data", 64'(rd_data), 64'(held));
            end
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                chk("rd.data", 64'(rd_data), 64'(ref_mem[beat]));
                chk("rd.last", 64'(rd_last), 64'(beat == ref_len - 1));
                beat++;
                stalled = 1'b0;
            end else if (rd_valid) begin
                stalled = 1'b1;
                held = rd_data;
            end
            cyc++;
            tick;
        end
        rd_ready = 1'b0;
        chk("rd.beats", 64'(beat), 64'(ref_len));
        if (mode == 0)
            chk("rd.throughput_cycles", 64'(cyc), 64'(ref_len + 1));
        chk("rd.rd_done", 64'(rd_done), 64'd1);
        chk("rd.busy_end", 64'(busy), 64'd0);
        chk("rd.valid_end", 64'(rd_valid), 64'd0);
        tick;
        chk("rd.rd_done_pulse", 64'(rd_done), 64'd0);
        chk("rd.nreads", 64'(rlog_add.size() - r0), 64'(ref_len));
        for (int i = 0; i < ref_len && r0 + i < rlog_add.size(); i++)
            chk("rd.raddr", 64'(rlog_add[r0+i]), 64'(i));
        chk("rd.no_writes", 64'(wlog_add.size() - w0), 64'd0);
    endtask

    initial begin
        int r0;
        rst       = 1'b1;
        start_acq = 1'b0;
        start_rd  = 1'b0;
        n_samples = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        rd_ready  = 1'b0;
        tick;
        tick;
        chk_all_zero("reset");
        rst = 1'b0;
        tick;
        chk_all_zero("post_reset");

        ref_len = 0;
        do_read(0);

        do_capture(4, 0, 32'hA0, 1'b0);
        do_read(0);
        do_read(1);

        do_capture(0, 0, -1, 1'b0);
        do_read(0);

        do_capture(4, 1, -1, 1'b0);
        do_read(2);

        do_capture(3, 0, -1, 1'b1);
        do_read(0);

        do_capture(17, 2, -1, 1'b0);
        do_read(1);

        for (int t = 0; t < 4; t++) begin
            do_capture(int'($urandom_range(0, 20)), 2, -1, 1'b0);
            do_read(2);
        end

        // reset in the middle of a stalled readback
        rd_ready = 1'b0;
        start_rd = 1'b1;
        tick;
        start_rd = 1'b0;
        tick;
        tick;
        chk("midrd.valid_before", 64'(rd_valid), 64'd1);
        rst = 1'b1;
        tick;
        chk_all_zero("midrd_reset");
        rst = 1'b0;
        tick;
        chk("midrd.no_rd_done", 64'(rd_done), 64'd0);
        ref_len = 0;
        r0 = rlog_add.size();
        do_read(0);
        chk("midrd.no_access", 64'(rlog_add.size() - r0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
